// File: rtl/serial_subtractor_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor controller.
//   DEFAULT_WIDTH : default operand/result width in bits
//   sub_state_t   : controller states (IDLE, RUN, DONE)
// ---------------------------------------------------------------------------
package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_state_t;

endpackage : serial_sub_pkg

// File: rtl/serial_subtractor_ctrl_sub_cell.sv
// ---------------------------------------------------------------------------
// sub_cell
// Combinational 1-bit full subtractor computing x - y - bi.
//   x  : minuend bit
//   y  : subtrahend bit
//   bi : borrow in
//   d  : difference bit
//   bo : borrow out
// ---------------------------------------------------------------------------
module sub_cell (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   // A borrow leaves this bit when y is set and x is clear, or when x and y
   // are equal and a borrow is already coming in from below.
   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule : sub_cell

// File: rtl/serial_subtractor_ctrl.sv
// ---------------------------------------------------------------------------
// serial_subtractor_ctrl
// Bit-serial WIDTH-bit subtractor: computes a - b - bin with one full
// subtractor cell over WIDTH clock cycles, LSB first, with a registered
// borrow chain and a start/done handshake.
//   clk   : system clock, rising-edge active
//   rst_n : asynchronous active-low reset
//   start : request a subtraction (sampled only in IDLE)
//   a, b  : minuend / subtrahend, captured on the accepted start edge
//   bin   : initial borrow-in, captured on the accepted start edge
//   busy  : high while the operation is in RUN
//   done  : one-cycle pulse, result valid
//   diff  : a - b - bin mod 2^WIDTH
//   bout  : final borrow-out (unsigned a < b + bin)
//   ovf   : signed two's-complement overflow
// ---------------------------------------------------------------------------
module serial_subtractor_ctrl
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   sub_state_t       state_q, state_d;
   logic [WIDTH-1:0] aSh_q, aSh_d;
   logic [WIDTH-1:0] bSh_q, bSh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             aMsb_q, aMsb_d;
   logic             bMsb_q, bMsb_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;
   logic             cellD, cellBo;
   logic [WIDTH-1:0] resNext;

   // The single arithmetic cell always works on the current LSBs of the
   // operand shift registers and the registered borrow.
   sub_cell uCell (
      .x  (aSh_q[0]),
      .y  (bSh_q[0]),
      .bi (br_q),
      .d  (cellD),
      .bo (cellBo)
   );

   // Result bits arrive LSB first, so they enter at the top and walk down;
   // after WIDTH shifts the first bit has reached position 0.
   assign resNext = {cellD, res_q[WIDTH-1:1]};

   // Next-state and datapath control. The operand MSBs are kept aside at
   // capture time because the shift registers no longer hold them when the
   // overflow flag is formed on the final bit.
   always_comb begin
      state_d = state_q;
      aSh_d   = aSh_q;
      bSh_d   = bSh_q;
      res_d   = res_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      aMsb_d  = aMsb_q;
      bMsb_d  = bMsb_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               aSh_d   = a;
               bSh_d   = b;
               br_d    = bin;
               cnt_d   = '0;
               aMsb_d  = a[WIDTH-1];
               bMsb_d  = b[WIDTH-1];
            end
         end
         RUN: begin
            res_d = resNext;
            aSh_d = aSh_q >> 1;
            bSh_d = bSh_q >> 1;
            br_d  = cellBo;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               cnt_d   = '0;
               diff_d  = resNext;
               bout_d  = cellBo;
               ovf_d   = (aMsb_q != bMsb_q) && (cellD != aMsb_q);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         aSh_q   <= '0;
         bSh_q   <= '0;
         res_q   <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         aMsb_q  <= 1'b0;
         bMsb_q  <= 1'b0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         aSh_q   <= aSh_d;
         bSh_q   <= bSh_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         aMsb_q  <= aMsb_d;
         bMsb_q  <= bMsb_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;

endmodule : serial_subtractor_ctrl

// File: tb/tb_serial_subtractor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor_ctrl
// Self-checking bench for serial_subtractor_ctrl with WIDTH = 8.
// ---------------------------------------------------------------------------
module tb_serial_subtractor_ctrl;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] diff;
      logic         bout;
      logic         ovf;
   } res_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      res_t         exp;
   } vec_t;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf;

   int   checkCount;
   int   errorCount;
   res_t sbQ[$];

   serial_subtractor_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout),
      .ovf   (ovf)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Absolute time limit so the run always ends.
   initial begin
      #1000000;
      $display("[TB] FAIL timeout: got no finish expected finish");
      $fatal(1, "[TB] time limit reached");
   end

   // Behavioural reference: full-width subtraction with one extra bit to
   // catch the borrow.
   function automatic res_t modelSub(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                     input logic mbin);
      logic [W:0] full;
      res_t       r;
      full   = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
      r.diff = full[W-1:0];
      r.bout = full[W];
      r.ovf  = (ma[W-1] != mb[W-1]) && (full[W-1] != ma[W-1]);
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got,
                              input logic [31:0] expv);
      checkCount++;
      if (got !== expv) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", name, got, expv);
      end
   endtask

   // Scoreboard consumer: every done pulse must match the oldest pending
   // expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sbQ.size() == 0) begin
            checkOutput("unexpected_done", 32'd1, 32'd0);
         end else begin
            res_t e;
            e = sbQ.pop_front();
            checkOutput("result", 32'({diff, bout, ovf}), 32'(e));
         end
      end
   end

   // Wait (at falling edges) until the DUT reports IDLE.
   task automatic waitIdle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (!busy && !done) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) checkOutput("wait_idle", 32'd0, 32'd1);
   endtask

   // Wait until every pending expectation has been consumed.
   task automatic waitDone();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (sbQ.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) checkOutput("wait_done", 32'd0, 32'd1);
   endtask

   // Launch one operation from IDLE and register its expected result.
   task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic vbin, input res_t expv);
      waitIdle();
      a     = va;
      b     = vb;
      bin   = vbin;
      start = 1'b1;
      sbQ.push_back(expv);
      @(negedge clk);
      start = 1'b0;
   endtask

   vec_t vecs[9];
   int   doneSeen;

   initial begin
      logic [W-1:0] corner[5];

      checkCount = 0;
      errorCount = 0;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;

      vecs[0] = '{8'h05, 8'h03, 1'b0, '{8'h02, 1'b0, 1'b0}};
      vecs[1] = '{8'h00, 8'h01, 1'b0, '{8'hFF, 1'b1, 1'b0}};
      vecs[2] = '{8'h10, 8'h0F, 1'b1, '{8'h00, 1'b0, 1'b0}};
      vecs[3] = '{8'h80, 8'h01, 1'b0, '{8'h7F, 1'b0, 1'b1}};
      vecs[4] = '{8'h7F, 8'hFF, 1'b0, '{8'h80, 1'b1, 1'b1}};
      vecs[5] = '{8'h00, 8'h00, 1'b1, '{8'hFF, 1'b1, 1'b0}};
      vecs[6] = '{8'hAA, 8'h55, 1'b0, '{8'h55, 1'b0, 1'b1}};
      vecs[7] = '{8'hFF, 8'hFF, 1'b1, '{8'hFF, 1'b1, 1'b0}};
      vecs[8] = '{8'h7F, 8'h80, 1'b0, '{8'hFF, 1'b1, 1'b1}};

      // Reset values.
      repeat (3) @(negedge clk);
      checkOutput("reset_outputs", 32'({busy, done, diff, bout, ovf}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Latency: busy for 8 cycles after the start edge, then one done cycle.
      $display("[TB] latency sequence");
      waitIdle();
      a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
      sbQ.push_back(res_t'{8'h02, 1'b0, 1'b0});
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         checkOutput($sformatf("busy_done_cycle%0d", i), 32'({busy, done}),
                     (i <= 8) ? 32'd2 : 32'd1);
      end
      waitDone();

      // Start held high: second operation begins on the first IDLE cycle.
      $display("[TB] held start sequence");
      waitIdle();
      a = 8'h09; b = 8'h04; bin = 1'b0; start = 1'b1;
      sbQ.push_back(res_t'{8'h05, 1'b0, 1'b0});
      sbQ.push_back(res_t'{8'h00, 1'b0, 1'b0});
      doneSeen = 0;
      for (int i = 1; i <= 11; i++) begin
         @(negedge clk);
         a = 8'h00; b = 8'h00;
         #1;
         if (i <= 10 && done) doneSeen++;
         if (i == 10) checkOutput("held_idle_gap", 32'({busy, done}), 32'd0);
         if (i == 11) checkOutput("held_restart", 32'(busy), 32'd1);
      end
      start = 1'b0;
      checkOutput("held_done_count", 32'(doneSeen), 32'd1);
      waitDone();

      // Table of fixed vectors.
      $display("[TB] vector table");
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp);
         waitDone();
      end

      // Reset in the middle of RUN discards the operation.
      $display("[TB] reset mid-operation");
      waitIdle();
      a = 8'hAA; b = 8'h55; bin = 1'b0; start = 1'b1;
      sbQ.push_back(res_t'{8'h55, 1'b0, 1'b1});
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      sbQ.delete();
      checkOutput("midreset_outputs", 32'({busy, done, diff, bout, ovf}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      doneSeen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         #1;
         if (done) doneSeen++;
      end
      checkOutput("midreset_no_done", 32'(doneSeen), 32'd0);
      applyStimulus(8'hAA, 8'h55, 1'b0, res_t'{8'h55, 1'b0, 1'b1});
      waitDone();

      // Corner-value sweep, then random pairs, against the reference model.
      $display("[TB] model sweep");
      corner[0] = 8'h00; corner[1] = 8'h01; corner[2] = 8'h7F;
      corner[3] = 8'h80; corner[4] = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < 5; j++) begin
            for (int k = 0; k < 2; k++) begin
               applyStimulus(corner[i], corner[j], k[0],
                             modelSub(corner[i], corner[j], k[0]));
               waitDone();
            end
         end
      end
      for (int n = 0; n < 2000; n++) begin
         logic [W-1:0] ra, rb;
         logic         rbin;
         ra   = W'($urandom_range(0, 255));
         rb   = W'($urandom_range(0, 255));
         rbin = 1'($urandom_range(0, 1));
         applyStimulus(ra, rb, rbin, modelSub(ra, rb, rbin));
         waitDone();
      end

      checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule : tb_serial_subtractor_ctrl
